// File: rtl/mem_arbiter_if.sv
// Bundle of both cache-side handshakes and the memory-side bus for mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 256
);
  logic                  ic_req;
  logic [WORD_SIZE-1:0]  ic_addr;
  logic [BLOCK_SIZE-1:0] ic_rdata;
  logic                  ic_done;

  logic                  dc_req;
  logic                  dc_we;
  logic [WORD_SIZE-1:0]  dc_addr;
  logic [BLOCK_SIZE-1:0] dc_wdata;
  logic [BLOCK_SIZE-1:0] dc_rdata;
  logic                  dc_done;

  logic                  mem_en;
  logic                  mem_we;
  logic [WORD_SIZE-1:0]  mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic [BLOCK_SIZE-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_rdata, ic_done, dc_rdata, dc_done,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_rdata, ic_done, dc_rdata, dc_done,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency block memory between the
// icache refill port and the dcache refill/write-back port.
module mem_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 256,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus
);

  localparam int CNT_W = 8;
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(32'h1F);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  prio_dc_q, prio_dc_d;  // 1 = dc wins a tie
  logic                  owner_dc_q, owner_dc_d;
  logic [WORD_SIZE-1:0]  addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] ic_rdata_q, ic_rdata_d;
  logic [BLOCK_SIZE-1:0] dc_rdata_q, dc_rdata_d;
  logic                  ic_done_q, ic_done_d;
  logic                  dc_done_q, dc_done_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_dc_d  = prio_dc_q;
    owner_dc_d = owner_dc_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_done_d  = 1'b0;
    dc_done_d  = 1'b0;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.ic_req && (!bus.dc_req || !prio_dc_q)) begin
          owner_dc_d = 1'b0;
          addr_d     = bus.ic_addr & ALIGN_MASK;
          we_d       = 1'b0;
          wdata_d    = '0;
          prio_dc_d  = 1'b1;
        end else if (bus.dc_req) begin
          owner_dc_d = 1'b1;
          addr_d     = bus.dc_addr & ALIGN_MASK;
          we_d       = bus.dc_we;
          wdata_d    = bus.dc_wdata;
          prio_dc_d  = 1'b0;
        end
        if (bus.ic_req || bus.dc_req) begin
          state_d  = ACCESS;
          cnt_d    = CNT_W'(LATENCY - 1);
          mem_en_d = 1'b1;
          mem_we_d = bus.ic_req && (!bus.dc_req || !prio_dc_q) ? 1'b0 : bus.dc_we;
          busy_d   = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          // Read data is only valid in the final enable cycle.
          if (!we_q) begin
            if (owner_dc_q) dc_rdata_d = bus.mem_rdata;
            else            ic_rdata_d = bus.mem_rdata;
          end
          ic_done_d = !owner_dc_q;
          dc_done_d = owner_dc_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prio_dc_q  <= 1'b0;
      owner_dc_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_dc_q  <= prio_dc_d;
      owner_dc_q <= owner_dc_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_done_q  <= ic_done_d;
      dc_done_q  <= dc_done_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.dc_done   = dc_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=4 instance for the main scenarios
// and a LATENCY=1 instance for the minimum-latency case.
module tb_mem_arbiter;

  localparam logic [255:0] BLK_A5 = {32{8'hA5}};
  localparam logic [255:0] BLK_80 = {8{32'hDEAD_0080}};

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic        en_l   [0:23];
  logic        we_l   [0:23];
  logic        icd_l  [0:23];
  logic        dcd_l  [0:23];
  logic        busy_l [0:23];
  logic [31:0] addr_l [0:23];
  logic [255:0] wd_l  [0:23];

  mem_arbiter_if #(.WORD_SIZE(32), .BLOCK_SIZE(256)) bus4 ();
  mem_arbiter_if #(.WORD_SIZE(32), .BLOCK_SIZE(256)) bus1 ();

  mem_arbiter #(.WORD_SIZE(32), .BLOCK_SIZE(256), .LATENCY(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  mem_arbiter #(.WORD_SIZE(32), .BLOCK_SIZE(256), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  function automatic logic [255:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_1220) return {32{8'hA5}};
    return {8{a ^ 32'hDEAD_0000}};
  endfunction

  assign bus4.mem_rdata = mem_model(bus4.mem_addr);
  assign bus1.mem_rdata = mem_model(bus1.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int i, input bit sel1);
    if (sel1) begin
      en_l[i] = bus1.mem_en;  we_l[i] = bus1.mem_we;  icd_l[i] = bus1.ic_done;
      dcd_l[i] = bus1.dc_done; busy_l[i] = bus1.busy; addr_l[i] = bus1.mem_addr;
      wd_l[i] = bus1.mem_wdata;
    end else begin
      en_l[i] = bus4.mem_en;  we_l[i] = bus4.mem_we;  icd_l[i] = bus4.ic_done;
      dcd_l[i] = bus4.dc_done; busy_l[i] = bus4.busy; addr_l[i] = bus4.mem_addr;
      wd_l[i] = bus4.mem_wdata;
    end
  endtask

  function automatic int count_hi(input int which, input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) begin
      case (which)
        0: c += int'(en_l[k]);
        1: c += int'(we_l[k]);
        2: c += int'(icd_l[k]);
        default: c += int'(dcd_l[k]);
      endcase
    end
    return c;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus4.ic_req = 1'b1; bus4.ic_addr = 32'h0000_1234;
    bus4.dc_req = 1'b1; bus4.dc_we = 1'b0; bus4.dc_addr = 32'h0000_0080; bus4.dc_wdata = '0;
    bus1.ic_req = 1'b0; bus1.ic_addr = '0;
    bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;

    // Reset with both requests already asserted.
    @(negedge clk);
    check("rst_mem_en",   bus4.mem_en,    0);
    check("rst_mem_we",   bus4.mem_we,    0);
    check("rst_busy",     bus4.busy,      0);
    check("rst_ic_done",  bus4.ic_done,   0);
    check("rst_dc_done",  bus4.dc_done,   0);
    check("rst_mem_addr", bus4.mem_addr,  0);
    check("rst_mem_wd",   bus4.mem_wdata, 0);
    check("rst_ic_rdata", bus4.ic_rdata,  0);
    check("rst_dc_rdata", bus4.dc_rdata,  0);

    // Both held continuously: ic, dc, ic, dc, six cycles apart.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      sample(i, 1'b0);
    end
    bus4.ic_req = 1'b0;
    bus4.dc_req = 1'b0;
    check("rr_first_ic_addr", addr_l[0],  32'h0000_1220);
    check("rr_busy_access",   busy_l[0],  1);
    check("rr_en_count",      count_hi(0, 0, 5), 4);
    check("rr_addr_stable",   addr_l[3],  32'h0000_1220);
    check("rr_ic_done_1",     icd_l[4],   1);
    check("rr_dc_quiet_1",    dcd_l[4],   0);
    check("rr_idle_busy",     busy_l[5],  0);
    check("rr_idle_en",       en_l[5],    0);
    check("rr_dc_grant_en",   en_l[6],    1);
    check("rr_dc_addr",       addr_l[6],  32'h0000_0080);
    check("rr_dc_done",       dcd_l[10],  1);
    check("rr_ic_addr_2",     addr_l[12], 32'h0000_1220);
    check("rr_ic_done_2",     icd_l[16],  1);
    check("rr_dc_addr_2",     addr_l[18], 32'h0000_0080);
    check("rr_dc_done_2",     dcd_l[22],  1);
    check("rr_ic_pulses",     count_hi(2, 0, 23), 2);
    check("rr_dc_pulses",     count_hi(3, 0, 23), 2);
    check("rr_ic_rdata",      bus4.ic_rdata, BLK_A5);
    check("rr_dc_rdata",      bus4.dc_rdata, BLK_80);

    // Dcache write-back.
    @(negedge clk);
    bus4.dc_req = 1'b1; bus4.dc_we = 1'b1; bus4.dc_addr = 32'h0000_0040; bus4.dc_wdata = 256'h1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      sample(j, 1'b0);
      if (j == 5) begin
        bus4.dc_req = 1'b0; bus4.dc_we = 1'b0;
      end
    end
    check("wb_en_count",  count_hi(0, 0, 5), 4);
    check("wb_we_count",  count_hi(1, 0, 5), 4);
    check("wb_addr",      addr_l[0], 32'h0000_0040);
    check("wb_addr_last", addr_l[3], 32'h0000_0040);
    check("wb_wdata",     wd_l[2],   256'h1);
    check("wb_we_done",   we_l[4],   0);
    check("wb_dc_done",   dcd_l[4],  1);
    check("wb_dc_pulses", count_hi(3, 0, 5), 1);
    check("wb_ic_quiet",  count_hi(2, 0, 5), 0);
    check("wb_dc_rdata",  bus4.dc_rdata, BLK_80);

    // Address change and request drop while the access is in flight.
    @(negedge clk);
    bus4.ic_req = 1'b1; bus4.ic_addr = 32'h0000_1234;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      sample(j, 1'b0);
      if (j == 0) begin
        bus4.ic_addr = 32'hFFFF_FFE0;
        bus4.ic_req  = 1'b0;
      end
    end
    check("mid_addr_1",    addr_l[1], 32'h0000_1220);
    check("mid_addr_3",    addr_l[3], 32'h0000_1220);
    check("mid_ic_done",   icd_l[4],  1);
    check("mid_ic_pulses", count_hi(2, 0, 5), 1);
    check("mid_dc_quiet",  count_hi(3, 0, 5), 0);
    check("mid_ic_rdata",  bus4.ic_rdata, BLK_A5);
    bus4.ic_addr = 32'h0000_1234;

    // Reset during the second ACCESS cycle aborts with no done pulse.
    @(negedge clk);
    bus4.ic_req = 1'b1;
    @(negedge clk);
    check("abort_en_before", bus4.mem_en, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus4.ic_req = 1'b0;
    #1;
    check("abort_en_now",   bus4.mem_en,   0);
    check("abort_busy_now", bus4.busy,     0);
    check("abort_ic_rdata", bus4.ic_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      sample(j, 1'b0);
    end
    check("abort_no_ic_done", count_hi(2, 0, 7), 0);
    check("abort_no_dc_done", count_hi(3, 0, 7), 0);
    check("abort_no_en",      count_hi(0, 0, 7), 0);

    // LATENCY=1 instance: ic then the pending dc.
    bus1.ic_req = 1'b1; bus1.ic_addr = 32'h0000_1234;
    bus1.dc_req = 1'b1; bus1.dc_we = 1'b0; bus1.dc_addr = 32'h0000_0080;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      sample(j, 1'b1);
      if (j == 2) bus1.ic_req = 1'b0;
      if (j == 4) bus1.dc_req = 1'b0;
    end
    check("l1_en_first",   en_l[0],   1);
    check("l1_addr_first", addr_l[0], 32'h0000_1220);
    check("l1_en_off",     en_l[1],   0);
    check("l1_ic_done",    icd_l[1],  1);
    check("l1_idle_en",    en_l[2],   0);
    check("l1_dc_en",      en_l[3],   1);
    check("l1_dc_addr",    addr_l[3], 32'h0000_0080);
    check("l1_dc_early",   dcd_l[3],  0);
    check("l1_dc_done",    dcd_l[4],  1);
    check("l1_en_count",   count_hi(0, 0, 5), 2);
    check("l1_ic_rdata",   bus1.ic_rdata, BLK_A5);
    check("l1_dc_rdata",   bus1.dc_rdata, BLK_80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single backing block memory and shares it between two requesters: instruction-cache refill (port ic) and data-cache refill/write-back (port dc).
- Sits between both caches and the memory array. It replaces per-cache fixed-delay stalls with a request/done handshake and a fixed-latency memory access.
- Each transaction moves one aligned block.

Parameters:
- WORD_SIZE, 32, address width in bits.
- BLOCK_SIZE, 256, block width in bits (32 bytes; address offset bits [4:0]).
- LATENCY, 4, number of cycles mem_en is held per access; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_req  in  1  icache refill request; held until ic_done.
- ic_addr  in  WORD_SIZE  icache miss address.
- ic_rdata  out  BLOCK_SIZE  refill block returned to icache.
- ic_done  out  1  one-cycle completion pulse.
- dc_req  in  1  dcache request; held until dc_done.
- dc_we  in  1  1 = block write-back, 0 = refill read.
- dc_addr  in  WORD_SIZE  dcache address.
- dc_wdata  in  BLOCK_SIZE  write-back data.
- dc_rdata  out  BLOCK_SIZE  refill block returned to dcache.
- dc_done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  WORD_SIZE  block-aligned address (bits [4:0] forced to 0).
- mem_wdata  out  BLOCK_SIZE  write data.
- mem_rdata  in  BLOCK_SIZE  read data; valid in the last mem_en cycle.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including ic_rdata and dc_rdata.
  - Counter 0; round-robin pointer favours ic.
- A reset that arrives mid-transaction aborts the access immediately. No done pulse is produced for the aborted transaction.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - At each rising edge, sample ic_req and dc_req.
  - Only one asserted: grant it.
  - Both asserted: grant the requester the pointer favours. The pointer then favours the other requester (round-robin).
  - Single grants also move the pointer away from the granted requester.
  - On grant, latch into registers:
    - owner;
    - aligned address (addr & ~32'h1F);
    - we (dc_we for dc, 0 for ic);
    - wdata.
  - Load counter=LATENCY-1 and move to ACCESS.
- ACCESS:
  - mem_en=1. mem_addr, mem_we and mem_wdata are driven from the latched registers and stay stable for exactly LATENCY cycles.
  - Counter decrements each cycle.
  - At the edge ending the cycle where counter==0:
    - For a read, capture mem_rdata into the owner's rdata register.
    - Move to DONE.
  - Writes leave both rdata registers unchanged.
- DONE:
  - mem_en=0 and mem_we=0.
  - The owner's done=1 for exactly this one cycle.
  - Next state is IDLE unconditionally.
- Latency: rising edge k samples req, so done is high during cycle k+LATENCY+1. With LATENCY=4, done appears 5 cycles after the sampling edge.
- Handshake rules:
  - A requester holds req and all of its inputs stable until it sees done.
  - The requester deasserts req in the cycle after done.
  - IDLE samples req one edge after DONE, so back-to-back requests cost one idle cycle.
  - The rdata registers hold their value until that requester's next read completes.
  - Changes to inputs after grant are ignored; only the latched values are used.
- Requester drops req mid-ACCESS: the access still completes and done still pulses.
- Reads and writes are never interleaved; there is only one outstanding transaction at a time.
- A request that is waiting while the other requester owns the memory is not lost. It is granted in the first IDLE cycle after the current transaction completes.
- Only the owner's done ever pulses. The non-owner's done stays 0 throughout.

Test Plan:
- Reset values: rst_n=0 at t=0, both reqs high → all outputs 0, busy=0. Release reset → ic is granted first.
- Single icache read, LATENCY=4:
  - Stimulus: ic_req=1, ic_addr=32'h0000_1234, mem model returns 256'hA5... for block 32'h1220.
  - Required response: mem_addr=32'h0000_1220 with mem_en=1 for exactly 4 cycles; ic_done=1 for exactly 1 cycle, 5 cycles after the sampling edge; ic_rdata=256'hA5...; dc_done=0 throughout.
- Dcache write-back:
  - Stimulus: dc_req=1, dc_we=1, dc_addr=32'h40, dc_wdata=256'h1.
  - Required response: mem_we=1 for 4 cycles; mem_wdata=256'h1; dc_done pulses once; dc_rdata unchanged.
- Simultaneous requests from reset, held continuously: both req asserted → grant order ic, dc, ic, dc. Each grant is separated by 6 cycles (4 ACCESS + 1 DONE + 1 IDLE).
- Mid-transaction effects:
  - Change ic_addr during ACCESS → mem_addr does not change.
  - Drop ic_req during ACCESS → ic_done still pulses.
  - Assert rst_n=0 during cycle 2 of ACCESS → mem_en falls immediately and no done pulse follows.
- LATENCY=1 build: req sampled → mem_en high for one cycle → done high on the following cycle. The pending dc request is served next.
